// File: rtl/read_wait_capture.sv
// ----------------------------------------------------------------------------
// read_wait_capture
//
// Purpose:
//   Sits between a simple memory-read master and a slow responder. A read
//   request (mem_read, sampled only while idle) starts a bounded wait for the
//   responder's data_ready level. When data_ready is seen, data_bus is
//   captured and presented on data/data_valid for HOLD cycles, then cleared.
//   If the wait exceeds TIMEOUT cycles the request is abandoned and a
//   one-cycle timeout pulse is produced. Successful captures are counted in
//   rd_count, which wraps silently.
//
// Parameters:
//   DATA_W  - width of data_bus and data
//   TIMEOUT - cycles allowed in the wait state before aborting (0 = forever)
//   HOLD    - cycles data/data_valid stay asserted after capture (>= 1)
//   CNT_W   - width of rd_count
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset, overrides everything
//   mem_read   in   read request, only looked at while idle
//   data_ready in   responder data-valid level
//   data_bus   in   responder data
//   data       out  captured word, 0 whenever data_valid is low
//   data_valid out  high while data holds a captured word
//   busy       out  high while waiting or holding
//   timeout    out  one-cycle pulse when a wait is abandoned
//   rd_count   out  number of successful captures, modulo 2^CNT_W
//
// All outputs come straight from flops; nothing combinational reaches them.
// ----------------------------------------------------------------------------
module read_wait_capture #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int HOLD    = 1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              data_ready,
    input  logic [DATA_W-1:0] data_bus,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              busy,
    output logic              timeout,
    output logic [CNT_W-1:0]  rd_count
);

    // Counter widths never drop below one bit so the degenerate settings
    // (TIMEOUT=0, HOLD=1) still produce legal vectors.
    localparam int WAIT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int HOLD_W = ($clog2(HOLD) < 1) ? 1 : $clog2(HOLD);

    localparam bit                TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [HOLD_W-1:0]   hold_cnt;

    // Single sequential block: state, counters and every output are updated
    // together so the outputs are always a registered view of the state.
    // The timeout flag defaults low each cycle, which makes it a pulse.
    // In the wait state data_ready is tested before the timeout limit, so a
    // response arriving on the last allowed cycle is captured, not dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            data       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            rd_count   <= '0;
            wait_cnt   <= '0;
            hold_cnt   <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_read) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (data_ready) begin
                        data       <= data_bus;
                        data_valid <= 1'b1;
                        rd_count   <= rd_count + CNT_W'(1);
                        hold_cnt   <= HOLD_LOAD;
                        state      <= ST_HOLD;
                    end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        data       <= '0;
                        data_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end

                default: begin
                    data       <= '0;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_wait_capture.sv
// ----------------------------------------------------------------------------
// tb_read_wait_capture
//
// Drives three instances of read_wait_capture from one shared stimulus:
//   inst 0: defaults           (TIMEOUT=16, HOLD=1, CNT_W=8)
//   inst 1: long hold          (TIMEOUT=16, HOLD=4, CNT_W=8)
//   inst 2: no timeout, 2-bit  (TIMEOUT=0,  HOLD=1, CNT_W=2)
// Every cycle each instance is compared with a reference model that tracks
// transactions by edge timestamps (request edge, capture edge) and derives
// the outputs from the elapsed edge counts.
// ----------------------------------------------------------------------------
module tb_read_wait_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read;
    logic       data_ready;
    logic [7:0] data_bus;

    logic [7:0] data_a, data_b, data_c;
    logic       valid_a, valid_b, valid_c;
    logic       busy_a, busy_b, busy_c;
    logic       tmo_a, tmo_b, tmo_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    read_wait_capture #(.DATA_W(8), .TIMEOUT(16), .HOLD(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .mem_read(mem_read), .data_ready(data_ready),
        .data_bus(data_bus), .data(data_a), .data_valid(valid_a),
        .busy(busy_a), .timeout(tmo_a), .rd_count(cnt_a)
    );

    read_wait_capture #(.DATA_W(8), .TIMEOUT(16), .HOLD(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .mem_read(mem_read), .data_ready(data_ready),
        .data_bus(data_bus), .data(data_b), .data_valid(valid_b),
        .busy(busy_b), .timeout(tmo_b), .rd_count(cnt_b)
    );

    read_wait_capture #(.DATA_W(8), .TIMEOUT(0), .HOLD(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .mem_read(mem_read), .data_ready(data_ready),
        .data_bus(data_bus), .data(data_c), .data_valid(valid_c),
        .busy(busy_c), .timeout(tmo_c), .rd_count(cnt_c)
    );

    // Reference model: per instance, a transaction is either absent, waiting
    // (no capture timestamp yet) or holding (capture timestamp known).
    int p_tmo[3]  = '{16, 16, 0};
    int p_hold[3] = '{1, 4, 1};
    int p_cntw[3] = '{8, 8, 2};

    int         edge_n = 0;
    bit         m_active[3];
    int         m_treq[3];
    int         m_tcap[3];
    int         m_ttmo[3];
    int         m_count[3];
    logic [7:0] m_word[3];

    typedef struct {
        logic       rst;
        logic       mem_read;
        logic       data_ready;
        logic [7:0] bus;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_busy;
        logic       exp_tmo;
        logic [7:0] exp_cnt;
    } vec_t;

    task automatic checkVal(input string name, input int inst,
                            input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s inst%0d edge %0d: got %0h want %0h",
                     name, inst, edge_n, got, want);
        end
    endtask

    task automatic modelStep();
        edge_n++;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_active[i] = 1'b0;
                m_tcap[i]   = -1;
                m_count[i]  = 0;
                m_word[i]   = 8'h00;
            end else if (!m_active[i]) begin
                if (mem_read) begin
                    m_active[i] = 1'b1;
                    m_treq[i]   = edge_n;
                    m_tcap[i]   = -1;
                end
            end else if (m_tcap[i] < 0) begin
                if (data_ready) begin
                    m_tcap[i] = edge_n;
                    m_word[i] = data_bus;
                    m_count[i]++;
                end else if (p_tmo[i] != 0 && (edge_n - m_treq[i]) == p_tmo[i]) begin
                    m_active[i] = 1'b0;
                    m_ttmo[i]   = edge_n;
                end
            end else if ((edge_n - m_tcap[i]) == p_hold[i]) begin
                m_active[i] = 1'b0;
            end
        end
    endtask

    task automatic checkOutput(input int i, input logic [7:0] d, input logic v,
                               input logic b, input logic t, input logic [7:0] c);
        bit         exp_v;
        logic [7:0] exp_d;
        exp_v = m_active[i] && (m_tcap[i] >= 0);
        exp_d = exp_v ? m_word[i] : 8'h00;
        checkVal("data", i, 32'(d), 32'(exp_d));
        checkVal("data_valid", i, 32'(v), 32'(exp_v));
        checkVal("busy", i, 32'(b), 32'(m_active[i]));
        checkVal("timeout", i, 32'(t), 32'(m_ttmo[i] == edge_n));
        checkVal("rd_count", i, 32'(c), 32'(m_count[i] % (1 << p_cntw[i])));
    endtask

    task automatic applyStimulus(input logic r, input logic m, input logic d,
                                 input logic [7:0] b);
        rst        = r;
        mem_read   = m;
        data_ready = d;
        data_bus   = b;
    endtask

    // One clock: model samples the same inputs the DUTs see at the edge,
    // outputs are compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(0, data_a, valid_a, busy_a, tmo_a, cnt_a);
        checkOutput(1, data_b, valid_b, busy_b, tmo_b, cnt_b);
        checkOutput(2, data_c, valid_c, busy_c, tmo_c, {6'b0, cnt_c});
    endtask

    task automatic idle(input int n);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        vec_t vecs[13];
        int   cnt_before;

        for (int i = 0; i < 3; i++) begin
            m_active[i] = 1'b0;
            m_treq[i]   = 0;
            m_tcap[i]   = -1;
            m_ttmo[i]   = -1;
            m_count[i]  = 0;
            m_word[i]   = 8'h00;
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

        // Reset, idle with data_ready high, then a basic HOLD=1 capture.
        vecs[0]  = '{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'd0};
        vecs[1]  = '{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'd0};
        vecs[2]  = '{0, 0, 1, 8'hFF, 8'h00, 0, 0, 0, 8'd0};
        vecs[3]  = '{0, 0, 1, 8'hFF, 8'h00, 0, 0, 0, 8'd0};
        vecs[4]  = '{0, 0, 1, 8'hFF, 8'h00, 0, 0, 0, 8'd0};
        vecs[5]  = '{0, 0, 1, 8'hFF, 8'h00, 0, 0, 0, 8'd0};
        vecs[6]  = '{0, 0, 1, 8'hFF, 8'h00, 0, 0, 0, 8'd0};
        vecs[7]  = '{0, 1, 0, 8'hDE, 8'h00, 0, 1, 0, 8'd0};
        vecs[8]  = '{0, 0, 0, 8'hDE, 8'h00, 0, 1, 0, 8'd0};
        vecs[9]  = '{0, 0, 0, 8'hDE, 8'h00, 0, 1, 0, 8'd0};
        vecs[10] = '{0, 0, 1, 8'hDE, 8'hDE, 1, 1, 0, 8'd1};
        vecs[11] = '{0, 0, 1, 8'hDE, 8'h00, 0, 0, 0, 8'd1};
        vecs[12] = '{0, 0, 0, 8'hDE, 8'h00, 0, 0, 0, 8'd1};

        $display("[TB] table vectors");
        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].mem_read, vecs[v].data_ready, vecs[v].bus);
            step();
            checkVal("vec_data", 0, 32'(data_a), 32'(vecs[v].exp_data));
            checkVal("vec_valid", 0, 32'(valid_a), 32'(vecs[v].exp_valid));
            checkVal("vec_busy", 0, 32'(busy_a), 32'(vecs[v].exp_busy));
            checkVal("vec_timeout", 0, 32'(tmo_a), 32'(vecs[v].exp_tmo));
            checkVal("vec_rd_count", 0, 32'(cnt_a), 32'(vecs[v].exp_cnt));
        end

        // HOLD=4: word must survive a bus change and ignore mem_read pulses.
        $display("[TB] hold length");
        idle(6);
        cnt_before = m_count[1];
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hAD);
        step();
        checkVal("hold_data", 1, 32'(data_b), 32'h00AD);
        for (int j = 1; j <= 4; j++) begin
            applyStimulus(1'b0, (j == 1 || j == 2), 1'b0, 8'h00);
            step();
            checkVal("hold_valid", 1, 32'(valid_b), 32'(j < 4));
            checkVal("hold_data", 1, 32'(data_b), (j < 4) ? 32'h00AD : 32'h0);
        end
        checkVal("hold_rd_count", 1, 32'(cnt_b), 32'(cnt_before + 1));

        // Timeout after exactly 16 wait cycles, then a capture on the 16th.
        $display("[TB] timeout");
        idle(20);
        cnt_before = m_count[0];
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            step();
            checkVal("tmo_pulse", 0, 32'(tmo_a), 32'(k == 16));
            checkVal("tmo_busy", 0, 32'(busy_a), 32'(k < 16));
            checkVal("tmo_valid", 0, 32'(valid_a), 32'h0);
        end
        step();
        checkVal("tmo_pulse_end", 0, 32'(tmo_a), 32'h0);
        checkVal("tmo_rd_count", 0, 32'(cnt_a), 32'(cnt_before % 256));

        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b0, (k == 16), 8'h3C);
            step();
            checkVal("late_tmo", 0, 32'(tmo_a), 32'h0);
        end
        checkVal("late_valid", 0, 32'(valid_a), 32'h1);
        checkVal("late_data", 0, 32'(data_a), 32'h003C);

        // Reset during WAIT, then during HOLD of the long-hold instance.
        $display("[TB] reset mid-operation");
        idle(6);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        idle(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        checkVal("rst_wait_busy", 0, 32'(busy_a), 32'h0);
        checkVal("rst_wait_cnt", 0, 32'(cnt_a), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A);
        step();
        checkVal("pre_rst_data", 1, 32'(data_b), 32'h005A);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h5A);
        step();
        checkVal("rst_hold_data", 1, 32'(data_b), 32'h0);
        checkVal("rst_hold_valid", 1, 32'(valid_b), 32'h0);
        checkVal("rst_hold_busy", 1, 32'(busy_b), 32'h0);
        checkVal("rst_hold_cnt", 1, 32'(cnt_b), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h77);
        step();
        checkVal("after_rst_data", 0, 32'(data_a), 32'h0077);
        checkVal("after_rst_cnt", 0, 32'(cnt_a), 32'h1);

        // 2-bit counter wrap: 1,2,3,0,1.
        $display("[TB] counter wrap");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        for (int r = 0; r < 5; r++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            step();
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(r + 1));
            step();
            checkVal("wrap_cnt", 2, 32'(cnt_c), 32'((r + 1) % 4));
            idle(5);
        end

        // TIMEOUT=0: waits 100 cycles with no pulse, then captures.
        $display("[TB] no-timeout wait");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            step();
            checkVal("forever_tmo", 2, 32'(tmo_c), 32'h0);
            checkVal("forever_busy", 2, 32'(busy_c), 32'h1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h99);
        step();
        checkVal("forever_data", 2, 32'(data_c), 32'h0099);
        checkVal("forever_valid", 2, 32'(valid_c), 32'h1);

        // Random traffic against the model.
        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(3) == 0),
                          ($urandom_range(2) == 0), 8'($urandom));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
